// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: loader FSM states and the
// default data width and frame start byte.
package cpu_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    INSTR,
    ARG,
    CSUM
  } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: 2^WIDTH entries of {instr, arg}. One synchronous write port
// and one asynchronous read port. A read of the entry being written in the
// same cycle returns the old contents. The contents are not reset.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               we,
  input  logic [WIDTH-1:0]   waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]   raddr,
  output logic [2*WIDTH-1:0] rdata
);

  logic [2*WIDTH-1:0] mem [2**WIDTH];

  // Write the incoming pair on the clock edge; no reset, so contents persist
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader feeding the CPU fetch path.
// Frame: HEADER, LEN, LEN x (INSTR, ARG), CSUM where CSUM = LEN + all pair
// bytes (mod 2^WIDTH). cpu_hold keeps the CPU in reset until a frame verifies.
// Optional: define PROG_LOADER_TIMEOUT_EN to abort a frame whose inter-byte
// gap reaches TIMEOUT_CYC cycles.
module prog_loader
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] HEADER = WIDTH'(HEADER_DEFAULT),
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] arg,
   output logic             cpu_hold,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] prog_len
);

   loader_state_t      state;
   loader_state_t      next_state;
   logic               ready_q;
   logic               accept;
   logic [WIDTH-1:0]   len;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   wa;
   logic [WIDTH-1:0]   wa_next;
   logic [WIDTH-1:0]   instr_hold;
   logic               mem_we;
   logic               timeout_hit;
   logic [2*WIDTH-1:0] rdata;

   assign in_ready = ready_q;
   assign accept   = in_valid && ready_q;
   assign wa_next  = wa + 1'b1;

`ifdef PROG_LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] tmo_cnt;

   assign timeout_hit = (tmo_cnt == TO_W'(TIMEOUT_CYC));

   // Count idle cycles mid-frame; any accepted byte or IDLE clears the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == IDLE || accept) begin
         tmo_cnt <= '0;
      end else if (!timeout_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and memory write strobe
   always_comb begin
      next_state = state;
      mem_we     = 1'b0;
      case (state)
         IDLE:  if (accept && in_data == HEADER) next_state = LEN;
         LEN:   if (accept) next_state = (in_data == '0) ? CSUM : INSTR;
         INSTR: if (accept) next_state = ARG;
         ARG: begin
            if (accept) begin
               mem_we     = 1'b1;
               next_state = (wa_next == len) ? CSUM : INSTR;
            end
         end
         CSUM:  if (accept) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (timeout_hit) begin
         next_state = IDLE;
         mem_we     = 1'b0;
      end
   end

   // Frame datapath: length, running checksum, write address and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         prog_len   <= '0;
         len        <= '0;
         sum        <= '0;
         wa         <= '0;
         instr_hold <= '0;
      end else begin
         ready_q <= 1'b1;
         done    <= 1'b0;
         if (timeout_hit) begin
            err      <= 1'b1;
            cpu_hold <= 1'b1;
         end else if (accept) begin
            case (state)
               IDLE: begin
                  if (in_data == HEADER) begin
                     cpu_hold <= 1'b1;
                     err      <= 1'b0;
                  end
               end
               LEN: begin
                  len <= in_data;
                  sum <= in_data;
                  wa  <= '0;
               end
               INSTR: begin
                  instr_hold <= in_data;
                  sum        <= sum + in_data;
               end
               ARG: begin
                  sum <= sum + in_data;
                  wa  <= wa_next;
               end
               CSUM: begin
                  if (in_data == sum) begin
                     done     <= 1'b1;
                     prog_len <= len;
                     cpu_hold <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   prog_mem #(
      .WIDTH(WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wa),
      .wdata ({instr_hold, in_data}),
      .raddr (addr),
      .rdata (rdata)
   );

   assign instr = rdata[2*WIDTH-1:WIDTH];
   assign arg   = rdata[WIDTH-1:0];

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: each frame's expected outcome (done with
// a length, or err) is queued when its checksum byte is sent; a monitor pops
// and checks whenever the loader raises done or err.
module tb_prog_loader;

   typedef struct {
      logic       is_done;
      logic [7:0] len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] addr = '0;
   logic [7:0] instr;
   logic [7:0] arg;
   logic       cpu_hold;
   logic       done;
   logic       err;
   logic [7:0] prog_len;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   logic err_prev = 1'b0;

   always #5 clk = ~clk;

   prog_loader #(
      .TIMEOUT_CYC(16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .addr     (addr),
      .instr    (instr),
      .arg      (arg),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err),
      .prog_len (prog_len)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // Send one byte after 'gap' idle cycles; returns at the negedge after acceptance
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic expectEvent(input logic is_done, input logic [7:0] len);
      exp_t e;
      e.is_done = is_done;
      e.len     = len;
      sb_q.push_back(e);
   endtask

   task automatic checkMem(input logic [7:0] a, input logic [7:0] ei, input logic [7:0] ea);
      addr = a;
      #1;
      checkOutput($sformatf("mem_instr[%0d]", a), 32'(instr), 32'(ei));
      checkOutput($sformatf("mem_arg[%0d]", a), 32'(arg), 32'(ea));
   endtask

   task automatic sendGoodFrame();
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h02, 1);
      applyStimulus(8'h10, 0);
      applyStimulus(8'h01, 2);
      applyStimulus(8'h20, 0);
      applyStimulus(8'h02, 0);
      expectEvent(1'b1, 8'd2);
      applyStimulus(8'h35, 0);
   endtask

   // Monitor: every done pulse or rising err must match the head of the queue
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done || (err && !err_prev)) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_event: done=%0b err=%0b, expected no event", done, err);
            end else begin
               e = sb_q.pop_front();
               checkOutput("event_done", 32'(done), 32'(e.is_done));
               checkOutput("event_err", 32'(err), 32'(!e.is_done));
               checkOutput("event_cpu_hold", 32'(cpu_hold), 32'(!e.is_done));
               if (e.is_done) checkOutput("event_prog_len", 32'(prog_len), 32'(e.len));
            end
         end
         err_prev = err;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int waited;
      logic [7:0] junk [6];
      junk = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};

      // 1. Reset values, then in_ready after release
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_prog_len", 32'(prog_len), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 2. Good two-pair frame
      sendGoodFrame();
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("good_cpu_hold", 32'(cpu_hold), 32'd0);
      checkMem(8'd0, 8'h10, 8'h01);
      checkMem(8'd1, 8'h20, 8'h02);

      // 3. Bad checksum, then resend the good frame
      applyStimulus(8'hA5, 0);
      checkOutput("hdr_reasserts_hold", 32'(cpu_hold), 32'd1);
      applyStimulus(8'h02, 0);
      applyStimulus(8'h10, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h20, 0);
      applyStimulus(8'h02, 0);
      expectEvent(1'b0, 8'd0);
      applyStimulus(8'h36, 0);
      checkOutput("bad_err", 32'(err), 32'd1);
      checkOutput("bad_no_done", 32'(done), 32'd0);
      @(negedge clk);
      checkOutput("bad_cpu_hold", 32'(cpu_hold), 32'd1);
      checkMem(8'd0, 8'h10, 8'h01);
      applyStimulus(8'hA5, 1);
      checkOutput("err_clears_on_hdr", 32'(err), 32'd0);
      checkOutput("hold_after_hdr", 32'(cpu_hold), 32'd1);
      applyStimulus(8'h02, 0);
      applyStimulus(8'h10, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h20, 0);
      applyStimulus(8'h02, 0);
      expectEvent(1'b1, 8'd2);
      applyStimulus(8'h35, 0);
      @(negedge clk);
      checkOutput("resend_cpu_hold", 32'(cpu_hold), 32'd0);

      // 4. Junk then an empty frame, with random gaps
      for (int i = 0; i < 6; i++) begin
         if (i == 5) expectEvent(1'b1, 8'd0);
         applyStimulus(junk[i], $urandom_range(0, 3));
      end
      @(negedge clk);
      checkOutput("empty_prog_len", 32'(prog_len), 32'd0);
      checkOutput("empty_cpu_hold", 32'(cpu_hold), 32'd0);

      // 5. Reset mid-frame, then a frame whose data contains the header value
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h03, 0);
      applyStimulus(8'h11, 0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("midrst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h07, 0);
      expectEvent(1'b1, 8'd1);
      applyStimulus(8'hAD, 0);
      @(negedge clk);
      checkOutput("inframe_hdr_cpu_hold", 32'(cpu_hold), 32'd0);
      checkMem(8'd0, 8'hA5, 8'h07);
      checkMem(8'd1, 8'h20, 8'h02);

`ifdef PROG_LOADER_TIMEOUT_EN
      // 6. Stall mid-frame until the timeout aborts it, then reload
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h02, 0);
      expectEvent(1'b0, 8'd0);
      repeat (20) @(negedge clk);
      checkOutput("timeout_err", 32'(err), 32'd1);
      checkOutput("timeout_cpu_hold", 32'(cpu_hold), 32'd1);
      sendGoodFrame();
      @(negedge clk);
      checkOutput("after_timeout_cpu_hold", 32'(cpu_hold), 32'd0);
`endif

      // Drain the scoreboard with a bounded wait
      waited = 0;
      while (sb_q.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
